// File: rtl/fetch_issue_ctrl_pkg.sv
// Shared types and ISA constants for the fetch/issue controller and its decoder.
package pc_pkg;

    // Branch control handed to the PC.
    typedef enum logic [1:0] {
        BR_NEXT = 2'b00,
        BR_ABS  = 2'b01,
        BR_REL3 = 2'b10,
        BR_REL6 = 2'b11
    } branch_t;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALTED
    } fi_state_t;

    // Opcode prefixes of the fixed 9-bit ISA.
    localparam logic [1:0] OPC_JMP = 2'b10;   // [8:7]
    localparam logic [2:0] OPC_BR6 = 3'b111;  // [8:6]
    localparam logic [2:0] OPC_SYS = 3'b110;  // [8:6], HALT / BR3 / NOP
    localparam logic [8:0] OP_HALT = 9'b110111111;

    // True when the word is the HALT instruction.
    function automatic logic f_is_halt(input logic [8:0] instr);
        return (instr == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_issue_ctrl_decoder.sv
// Combinational decode of a 9-bit instruction into raw PC branch controls.
module instr_decoder
    import pc_pkg::*;
(
    input  logic [8:0] i_instr,
    output branch_t    o_branch,
    output logic [6:0] o_seven,
    output logic [2:0] o_three,
    output logic [5:0] o_six,
    output logic       o_is_halt
);

    // Decode opcode; fields not used by the decoded type stay zero.
    always_comb begin
        o_branch  = BR_NEXT;
        o_seven   = '0;
        o_three   = '0;
        o_six     = '0;
        o_is_halt = 1'b0;
        if (i_instr[8]) begin
            if (i_instr[8:7] == OPC_JMP) begin
                o_branch = BR_ABS;
                o_seven  = i_instr[6:0];
            end else if (i_instr[8:6] == OPC_BR6) begin
                o_branch = BR_REL6;
                o_six    = i_instr[5:0];
            end else if (f_is_halt(i_instr)) begin
                o_is_halt = 1'b1;
            end else if (!i_instr[5]) begin
                o_branch = BR_REL3;
                o_three  = i_instr[2:0];
            end
        end
    end

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue controller feeding the PC: captures the instruction word,
// issues it to execute over valid/ready and gates PC advance.
module fetch_issue_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned IW    = 9,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             imem_valid,
    input  logic [IW-1:0]    imem_rdata,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [IW-1:0]    instr_q,
    output logic [1:0]       branchType,
    output logic [6:0]       sevenBitAddress,
    output logic [2:0]       threeBitOffset,
    output logic [5:0]       sixBitOffset,
    output logic             pc_step,
    output logic             pc_reset,
    output logic             done,
    output logic [CNT_W-1:0] inst_count
);

    fi_state_t        r_state;
    fi_state_t        w_state_nxt;
    logic [IW-1:0]    r_instr;
    logic [CNT_W-1:0] r_inst_count;
    branch_t          w_branch;
    logic             w_is_halt;
    logic             w_handshake;

    instr_decoder u_dec (
        .i_instr   (r_instr),
        .o_branch  (w_branch),
        .o_seven   (sevenBitAddress),
        .o_three   (threeBitOffset),
        .o_six     (sixBitOffset),
        .o_is_halt (w_is_halt)
    );

    // Outputs derived from state so reset takes effect in the same cycle.
    always_comb begin
        ex_valid    = (r_state == ISSUE);
        w_handshake = ex_valid && ex_ready;
        pc_step     = w_handshake && !w_is_halt;
        pc_reset    = (r_state == IDLE);
        done        = (r_state == HALTED);
        instr_q     = r_instr;
        branchType  = w_branch;
        inst_count  = r_inst_count;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)       w_state_nxt = FETCH;
            FETCH:   if (imem_valid)  w_state_nxt = ISSUE;
            ISSUE:   if (w_handshake) w_state_nxt = w_is_halt ? HALTED : FETCH;
            HALTED:  if (start)       w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Instruction capture; held through ISSUE so decoded fields stay stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               r_instr <= '0;
        else if (r_state == FETCH && imem_valid)  r_instr <= imem_rdata;
    end

    // Retired-instruction counter, cleared on program start, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inst_count <= '0;
        end else if (r_state == IDLE && start) begin
            r_inst_count <= '0;
        end else if (pc_step && r_inst_count != '1) begin
            r_inst_count <= r_inst_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Scoreboard bench for fetch_issue_ctrl (built with a 4-bit counter so
// saturation is reachable quickly).
module tb_fetch_issue_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          imem_valid = 1'b0;
    logic [8:0]    imem_rdata = '0;
    logic          ex_ready = 1'b0;
    logic          ex_valid;
    logic [8:0]    instr_q;
    logic [1:0]    branchType;
    logic [6:0]    sevenBitAddress;
    logic [2:0]    threeBitOffset;
    logic [5:0]    sixBitOffset;
    logic          pc_step;
    logic          pc_reset;
    logic          done;
    logic [CW-1:0] inst_count;

    fetch_issue_ctrl #(.IW(9), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .imem_valid      (imem_valid),
        .imem_rdata      (imem_rdata),
        .ex_ready        (ex_ready),
        .ex_valid        (ex_valid),
        .instr_q         (instr_q),
        .branchType      (branchType),
        .sevenBitAddress (sevenBitAddress),
        .threeBitOffset  (threeBitOffset),
        .sixBitOffset    (sixBitOffset),
        .pc_step         (pc_step),
        .pc_reset        (pc_reset),
        .done            (done),
        .inst_count      (inst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]    instr;
        logic [1:0]    bt;
        logic [6:0]    s7;
        logic [2:0]    s3;
        logic [5:0]    s6;
        logic          step;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [CW-1:0] exp_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted issue is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && ex_valid && ex_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_issue", 32'(instr_q), 32'h1ff);
                end else begin
                    e = sb.pop_front();
                    check("mon_instr_q", 32'(instr_q), 32'(e.instr));
                    check("mon_branchType", 32'(branchType), 32'(e.bt));
                    check("mon_sevenBit", 32'(sevenBitAddress), 32'(e.s7));
                    check("mon_threeBit", 32'(threeBitOffset), 32'(e.s3));
                    check("mon_sixBit", 32'(sixBitOffset), 32'(e.s6));
                    check("mon_pc_step", 32'(pc_step), 32'(e.step));
                    check("mon_count_before", 32'(inst_count), 32'(e.cnt));
                end
            end
        end
    end

    // Fetch one word (entered in FETCH), stall, then hand it over.
    // A spurious imem_valid with a different word is driven throughout ISSUE.
    task automatic run_instr(input logic [8:0] ins, input int stall, input logic [1:0] bt,
                             input logic [6:0] s7, input logic [2:0] s3, input logic [5:0] s6,
                             input logic halt);
        exp_t e;
        imem_valid = 1'b1;
        imem_rdata = ins;
        ex_ready   = 1'b0;
        @(posedge clk); #1;
        imem_rdata = ~ins;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_ex_valid", 32'(ex_valid), 32'd1);
            check("stall_pc_step", 32'(pc_step), 32'd0);
            check("stall_instr_q", 32'(instr_q), 32'(ins));
            check("stall_branchType", 32'(branchType), 32'(bt));
            @(posedge clk); #1;
        end
        e.instr = ins; e.bt = bt; e.s7 = s7; e.s3 = s3; e.s6 = s6;
        e.step  = !halt;
        e.cnt   = exp_count;
        sb.push_back(e);
        if (!halt && exp_count != '1) exp_count = exp_count + 1'b1;
        ex_ready = 1'b1;
        @(posedge clk); #1;
        ex_ready   = 1'b0;
        imem_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        // Reset state after power-up reset.
        #12 reset = 1'b1;
        @(negedge clk);
        check("rst_pc_reset", 32'(pc_reset), 32'd1);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_inst_count", 32'(inst_count), 32'd0);
        check("rst_instr_q", 32'(instr_q), 32'd0);
        @(posedge clk); #1;

        // Reset mid-ISSUE holding a JMP.
        pulse_start();
        imem_valid = 1'b1;
        imem_rdata = 9'b10_1110001;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        check("pre_rst_ex_valid", 32'(ex_valid), 32'd1);
        check("pre_rst_branchType", 32'(branchType), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_ex_valid", 32'(ex_valid), 32'd0);
        check("midrst_pc_reset", 32'(pc_reset), 32'd1);
        check("midrst_branchType", 32'(branchType), 32'd0);
        check("midrst_sevenBit", 32'(sevenBitAddress), 32'd0);
        check("midrst_pc_step", 32'(pc_step), 32'd0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check("idle_pc_reset", 32'(pc_reset), 32'd1);
        pulse_start();
        check("fetch_pc_reset", 32'(pc_reset), 32'd0);
        check("fetch_ex_valid", 32'(ex_valid), 32'd0);

        // JMP, no stall.
        run_instr(9'b10_0101010, 0, 2'b01, 7'h2A, 3'd0, 6'd0, 1'b0);
        check("jmp_inst_count", 32'(inst_count), 32'd1);
        check("jmp_pc_step_low", 32'(pc_step), 32'd0);

        // start while in FETCH is ignored.
        pulse_start();
        check("fetch_start_pc_reset", 32'(pc_reset), 32'd0);
        check("fetch_start_ex_valid", 32'(ex_valid), 32'd0);
        check("fetch_start_done", 32'(done), 32'd0);

        // BR3 with three stall cycles, BR6, other decodes.
        run_instr(9'b110_000_101, 3, 2'b10, 7'd0, 3'b101, 6'd0, 1'b0);
        run_instr(9'b111_110000, 0, 2'b11, 7'd0, 3'd0, 6'b110000, 1'b0);
        run_instr(9'b110_011_010, 1, 2'b10, 7'd0, 3'b010, 6'd0, 1'b0);
        run_instr(9'b110_100_000, 0, 2'b00, 7'd0, 3'd0, 6'd0, 1'b0);
        run_instr(9'b0_1100_1010, 0, 2'b00, 7'd0, 3'd0, 6'd0, 1'b0);
        check("mix_inst_count", 32'(inst_count), 32'd6);

        // HALT.
        run_instr(9'b110111111, 1, 2'b00, 7'd0, 3'd0, 6'd0, 1'b1);
        check("halt_done", 32'(done), 32'd1);
        check("halt_ex_valid", 32'(ex_valid), 32'd0);
        check("halt_pc_step", 32'(pc_step), 32'd0);
        check("halt_inst_count", 32'(inst_count), 32'd6);
        pulse_start();
        check("restart_pc_reset", 32'(pc_reset), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        pulse_start();
        exp_count = '0;
        check("restart_count_clear", 32'(inst_count), 32'd0);

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            logic [8:0] w;
            w = 9'(i * 7) & 9'h0FF;
            run_instr(w, 0, 2'b00, 7'd0, 3'd0, 6'd0, 1'b0);
        end
        check("sat_inst_count", 32'(inst_count), 32'hF);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
